// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Signed ops run on operand magnitudes; the sign is restored in FIX.
module muldiv_seq #(
  parameter  int XLEN  = 32,
  parameter  int OPT_W = 4,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [OPT_W-1:0] opt,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic             div_zero
);

  localparam logic [OPT_W-1:0] OP_MUL   = OPT_W'(0);
  localparam logic [OPT_W-1:0] OP_MULHU = OPT_W'(1);
  localparam logic [OPT_W-1:0] OP_MULH  = OPT_W'(2);
  localparam logic [OPT_W-1:0] OP_DIVU  = OPT_W'(3);
  localparam logic [OPT_W-1:0] OP_REMU  = OPT_W'(4);
  localparam logic [OPT_W-1:0] OP_DIV   = OPT_W'(5);
  localparam logic [OPT_W-1:0] OP_REM   = OPT_W'(6);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [OPT_W-1:0]  op_q;
  logic [XLEN-1:0]   hi, lo, dvs;   // hi:lo = product, or remainder:quotient
  logic              neg_q;

  // accept-time decode
  logic              sgn_op, a_neg, b_neg, neg_in, b_zero, min_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              fast;
  logic [XLEN-1:0]   fast_res;
  logic              fast_dz;

  // iteration and fix-up datapath
  logic              is_div;
  logic [XLEN:0]     sum, trial;
  logic              ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_res;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Operand decode: magnitudes, result sign and the short-circuit cases.
  always_comb begin
    sgn_op   = (opt == OP_MULH) || (opt == OP_DIV) || (opt == OP_REM);
    a_neg    = a[XLEN-1];
    b_neg    = b[XLEN-1];
    a_mag    = (sgn_op && a_neg) ? -a : a;
    b_mag    = (sgn_op && b_neg) ? -b : b;
    neg_in   = 1'b0;
    if ((opt == OP_MULH) || (opt == OP_DIV)) neg_in = a_neg ^ b_neg;
    if (opt == OP_REM)                       neg_in = a_neg;
    b_zero   = (b == '0);
    min_ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast     = 1'b0;
    fast_res = '0;
    fast_dz  = 1'b0;
    case (opt)
      OP_MUL, OP_MULHU, OP_MULH: ;
      OP_DIVU, OP_DIV: begin
        if (b_zero) begin
          fast = 1'b1; fast_res = '1; fast_dz = 1'b1;
        end else if ((opt == OP_DIV) && min_ovf) begin
          fast = 1'b1; fast_res = a;
        end
      end
      OP_REMU, OP_REM: begin
        if (b_zero) begin
          fast = 1'b1; fast_res = a; fast_dz = 1'b1;
        end else if ((opt == OP_REM) && min_ovf) begin
          fast = 1'b1; fast_res = '0;
        end
      end
      default: fast = 1'b1;
    endcase
  end

  // One multiply or divide step, plus the sign fix-up of the final value.
  always_comb begin
    is_div   = (op_q == OP_DIVU) || (op_q == OP_REMU) ||
               (op_q == OP_DIV)  || (op_q == OP_REM);
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    trial    = {hi, lo[XLEN-1]} - {1'b0, dvs};
    ge       = ~trial[XLEN];
    prod_fix = neg_q ? -{hi, lo} : {hi, lo};
    case (op_q)
      OP_MULHU, OP_MULH: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIVU, OP_DIV:   fix_res = neg_q ? -lo : lo;
      OP_REMU, OP_REM:   fix_res = neg_q ? -hi : hi;
      default:           fix_res = prod_fix[XLEN-1:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: IDLE -> CALC (XLEN steps) -> FIX -> DONE, or IDLE -> DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = fast ? S_DONE : S_CALC;
      S_CALC: if (cnt == CNT_W'(1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate in CALC, publish result before DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          op_q  <= opt;
          hi    <= '0;
          lo    <= a_mag;
          dvs   <= b_mag;
          neg_q <= neg_in;
          cnt   <= CNT_W'(XLEN);
          if (fast) begin
            result   <= fast_res;
            div_zero <= fast_dz;
          end
        end
        S_CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            hi <= ge ? trial[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
            lo <= {lo[XLEN-2:0], ge};
          end else begin
            hi <= sum[XLEN:1];
            lo <= {sum[0], lo[XLEN-1:1]};
          end
        end
        S_FIX: begin
          result   <= fix_res;
          div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: a 32-bit and an 8-bit instance, checked every cycle
// against an arithmetic reference model, plus directed literal vectors.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req32 = 1'b0, req8 = 1'b0;
  logic [3:0]  opt32 = '0, opt8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] res32;
  logic [7:0]  res8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .req(req32), .opt(opt32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .div_zero(dz32));

  muldiv_seq #(.XLEN(8)) u8 (
    .clk(clk), .reset(reset), .req(req8), .opt(opt8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .div_zero(dz8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // Reference arithmetic for a w-bit unit, in plain 64-bit integers.
  function automatic void model(input int w, input logic [3:0] op,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic dz, output logic fast);
    logic [63:0] mask, ua, ub, up;
    longint sa, sb, mn, sp;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, x} & mask;
    ub = {32'b0, y} & mask;
    sa = ua[w-1] ? signed'(ua) - (longint'(1) << w) : signed'(ua);
    sb = ub[w-1] ? signed'(ub) - (longint'(1) << w) : signed'(ub);
    mn = -(longint'(1) << (w-1));
    up = ua * ub;
    sp = sa * sb;
    r = '0; dz = 1'b0; fast = 1'b0;
    case (op)
      4'd0: r = up[31:0] & mask[31:0];
      4'd1: r = 32'(up >> w);
      4'd2: r = 32'(sp >>> w) & mask[31:0];
      4'd3: if (ub == 0) begin r = mask[31:0]; dz = 1'b1; fast = 1'b1; end
            else r = 32'(ua / ub);
      4'd4: if (ub == 0) begin r = ua[31:0]; dz = 1'b1; fast = 1'b1; end
            else r = 32'(ua % ub);
      4'd5: if (ub == 0) begin r = mask[31:0]; dz = 1'b1; fast = 1'b1; end
            else if (sa == mn && sb == -1) begin r = ua[31:0]; fast = 1'b1; end
            else r = 32'(sa / sb) & mask[31:0];
      4'd6: if (ub == 0) begin r = ua[31:0]; dz = 1'b1; fast = 1'b1; end
            else if (sa == mn && sb == -1) begin r = '0; fast = 1'b1; end
            else r = 32'(sa % sb) & mask[31:0];
      default: fast = 1'b1;
    endcase
  endfunction

  // Per-instance model state: cycles left until done, shown and pending result.
  int          left[2] = '{0, 0};
  logic [31:0] exp_res[2] = '{32'h0, 32'h0};
  logic [31:0] pend_res[2] = '{32'h0, 32'h0};
  logic        exp_dz[2] = '{1'b0, 1'b0};
  logic        pend_dz[2] = '{1'b0, 1'b0};
  logic        c_busy, c_done, c_dz, c_req, c_fast;
  logic [31:0] c_res, c_a, c_b;
  logic [3:0]  c_opt;
  int          c_w;

  // Compare both instances against the model every cycle, then advance it.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        c_busy = busy32; c_done = done32; c_dz = dz32; c_res = res32;
        c_req = req32; c_opt = opt32; c_a = a32; c_b = b32; c_w = 32;
      end else begin
        c_busy = busy8; c_done = done8; c_dz = dz8; c_res = {24'b0, res8};
        c_req = req8; c_opt = opt8; c_a = {24'b0, a8}; c_b = {24'b0, b8}; c_w = 8;
      end
      if (left[i] == 1) begin
        exp_res[i] = pend_res[i];
        exp_dz[i]  = pend_dz[i];
      end
      chk($sformatf("busy_x%0d", c_w), 32'(c_busy), 32'(left[i] > 0));
      chk($sformatf("done_x%0d", c_w), 32'(c_done), 32'(left[i] == 1));
      chk($sformatf("result_x%0d", c_w), c_res, exp_res[i]);
      chk($sformatf("div_zero_x%0d", c_w), 32'(c_dz), 32'(exp_dz[i]));
      if (reset) begin
        left[i] = 0; exp_res[i] = '0; exp_dz[i] = 1'b0;
      end else if (left[i] > 0) begin
        left[i]--;
      end else if (c_req) begin
        model(c_w, c_opt, c_a, c_b, pend_res[i], pend_dz[i], c_fast);
        left[i] = c_fast ? 1 : c_w + 2;
      end
    end
  end

  // Counts cycles (from the next edge) until done; -1 and a FAIL on timeout.
  task automatic wait_done(input bit w8, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (w8 ? done8 : done32) begin cyc = k; break; end
    end
    if (cyc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: no done within 100 cycles");
    end
  endtask

  // Issue one request in an idle cycle; lat = cycles from accept to done.
  task automatic run_op(input bit w8, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] r,
                        output logic dz, output int lat);
    int cyc;
    @(posedge clk); #1;
    if (w8) begin req8 = 1'b1; opt8 = op; a8 = x[7:0]; b8 = y[7:0]; end
    else    begin req32 = 1'b1; opt32 = op; a32 = x; b32 = y; end
    @(posedge clk); #1;
    req8 = 1'b0; req32 = 1'b0;
    if (w8 ? done8 : done32) lat = 1;
    else begin
      wait_done(w8, cyc);
      lat = (cyc < 0) ? -1 : cyc + 1;
    end
    r  = w8 ? {24'b0, res8} : res32;
    dz = w8 ? dz8 : dz32;
  endtask

  task automatic dir(input string nm, input bit w8, input logic [3:0] op,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic edz, input int elat);
    logic [31:0] r; logic dz; int lat;
    run_op(w8, op, x, y, r, dz, lat);
    chk({nm, " result"}, r, er);
    chk({nm, " div_zero"}, 32'(dz), 32'(edz));
    chk({nm, " latency"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    logic [31:0] mr, x, y, r;
    logic        mdz, mf, dz;
    logic [3:0]  op;
    int          lat, cyc, ndone;

    // pin the model on a few hand-computed values
    model(32, 4'd2, 32'hFFFFFFFD, 32'd5, mr, mdz, mf);
    chk("model mulh", mr, 32'hFFFFFFFF);
    model(32, 4'd5, 32'hFFFFFFF9, 32'd2, mr, mdz, mf);
    chk("model div", mr, 32'hFFFFFFFD);
    model(8, 4'd6, 32'h80, 32'hFF, mr, mdz, mf);
    chk("model rem ovf", {mr[30:0], mf}, 32'h1);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy32), 32'h0);
    chk("reset done", 32'(done32), 32'h0);
    chk("reset result", res32, 32'h0);
    chk("reset result8", {24'b0, res8}, 32'h0);

    dir("mul 7*6",       0, 4'd0, 32'd7,        32'd6,        32'd42,       0, 34);
    dir("mulhu max",     0, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 34);
    dir("mulh -3*5",     0, 4'd2, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 0, 34);
    dir("mul -3*5",      0, 4'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 0, 34);
    dir("mulh min*min",  0, 4'd2, 32'h80000000, 32'h80000000, 32'h40000000, 0, 34);
    dir("div -7/2",      0, 4'd5, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 34);
    dir("rem -7/2",      0, 4'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 34);
    dir("div 7/-2",      0, 4'd5, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 34);
    dir("rem 7/-2",      0, 4'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        0, 34);
    dir("divu 100/7",    0, 4'd3, 32'd100,      32'd7,        32'd14,       0, 34);
    dir("remu 100/7",    0, 4'd4, 32'd100,      32'd7,        32'd2,        0, 34);
    dir("div min/1",     0, 4'd5, 32'h80000000, 32'd1,        32'h80000000, 0, 34);
    dir("divu 5/0",      0, 4'd3, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1);
    dir("rem 5/0",       0, 4'd6, 32'd5,        32'd0,        32'd5,        1, 1);
    dir("div min/-1",    0, 4'd5, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1);
    dir("rem min/-1",    0, 4'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 1);
    dir("opt 0xF",       0, 4'hF, 32'd9,        32'd3,        32'd0,        0, 1);
    dir("x8 mul wrap",   1, 4'd0, 32'h10,       32'h10,       32'h00,       0, 10);
    dir("x8 mulhu",      1, 4'd1, 32'hFF,       32'hFF,       32'hFE,       0, 10);
    dir("x8 div -127/2", 1, 4'd5, 32'h81,       32'h02,       32'hC1,       0, 10);
    dir("x8 div min/-1", 1, 4'd5, 32'h80,       32'hFF,       32'h80,       0, 1);

    // a request pulsed mid-CALC is ignored
    @(posedge clk); #1;
    req32 = 1'b1; opt32 = 4'd0; a32 = 32'd7; b32 = 32'd6;
    @(posedge clk); #1 req32 = 1'b0;
    repeat (5) @(posedge clk);
    #1 req32 = 1'b1; opt32 = 4'd3; a32 = 32'd1; b32 = 32'd1;
    @(posedge clk); #1 req32 = 1'b0;
    wait_done(0, cyc);
    chk("ignore result", res32, 32'd42);
    @(posedge clk); #1;
    chk("ignore idle", 32'(busy32), 32'h0);

    // reset mid-CALC aborts with no done
    @(posedge clk); #1;
    req32 = 1'b1; opt32 = 4'd0; a32 = 32'd3; b32 = 32'd3;
    @(posedge clk); #1 req32 = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort busy", 32'(busy32), 32'h0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'h0);

    // back-to-back with req held high
    @(posedge clk); #1;
    req32 = 1'b1; opt32 = 4'd0; a32 = 32'd7; b32 = 32'd6;
    @(posedge clk); #1 a32 = 32'd3; b32 = 32'd5;
    wait_done(0, cyc);
    chk("b2b first lat", 32'(cyc), 32'd33);
    chk("b2b first result", res32, 32'd42);
    @(posedge clk); #1;
    chk("b2b idle gap", 32'(busy32), 32'h0);
    @(posedge clk); #1;
    chk("b2b reaccept", 32'(busy32), 32'h1);
    req32 = 1'b0;
    wait_done(0, cyc);
    chk("b2b second lat", 32'(cyc), 32'd33);
    chk("b2b second result", res32, 32'd15);

    // random operands against the model, both widths
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 7));
      x  = 32'($urandom_range(0, 255));
      y  = (i % 7 == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      if (i % 11 == 0) begin op = (i % 2 == 0) ? 4'd5 : 4'd6; x = 32'h80; y = 32'hFF; end
      run_op(1, op, x, y, r, dz, lat);
      model(8, op, x, y, mr, mdz, mf);
      chk("rand8 result", r, mr);
      chk("rand8 div_zero", 32'(dz), 32'(mdz));
      chk("rand8 latency", 32'(lat), mf ? 32'd1 : 32'd10);
    end
    for (int i = 0; i < 10; i++) begin
      op = 4'($urandom_range(0, 6));
      x  = $urandom;
      y  = $urandom;
      run_op(0, op, x, y, r, dz, lat);
      model(32, op, x, y, mr, mdz, mf);
      chk("rand32 result", r, mr);
      chk("rand32 latency", 32'(lat), mf ? 32'd1 : 32'd34);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
